// File: rtl/friscv_pkg.sv
// friscv_pkg: shared types and constants for the RV32I decode stage.
//   ARCH         datapath / PC width
//   opcode_e     RV32I major opcodes handled by the decoder
//   alu_op_t     ALU_OPS encoding consumed by the execute stage
//   dec_state_e  skid-buffer occupancy (EMPTY / MAIN / FULL)
//   dec_bundle_t everything execute needs for one instruction
package friscv_pkg;

  localparam int ARCH = 32;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OPIMM  = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_SLT = 4'd2,
    ALU_SLL = 4'd3,
    ALU_SLR = 4'd4,
    ALU_SAR = 4'd5,
    ALU_XOR = 4'd6,
    ALU_OR  = 4'd7,
    ALU_AND = 4'd8
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_FULL  = 2'd2
  } dec_state_e;

  typedef struct packed {
    alu_op_t          alu_op;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [ARCH-1:0]  imm;
    logic             op_a_sel;  // 0: rs1, 1: PC
    logic             op_b_sel;  // 0: rs2, 1: imm
    logic             rd_we;
    logic             mem_re;
    logic             mem_we;
    logic             branch;
    logic             jump;
    logic [2:0]       funct3;
    logic [ARCH-1:0]  pc;
    logic             illegal;
  } dec_bundle_t;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/friscv_decoder_if.sv
// friscv_decoder_if: fetch->decode and decode->execute handshakes.
//   Signal names carry the decoder's point of view (_i into it, _o out of it).
//   slave  : decoder side
//   master : surrounding pipeline (fetch + execute) side
// Handshake: a transfer happens on a rising clock edge when valid and ready are
// both high; a producer holds valid and its payload stable until that edge, and
// ready never depends combinationally on valid.
interface friscv_decoder_if;
  import friscv_pkg::*;

  logic             flush_i;
  logic             instr_valid_i;
  logic             instr_ready_o;
  logic [31:0]      instr_i;
  logic [ARCH-1:0]  pc_i;

  logic             dec_valid_o;
  logic             dec_ready_i;
  alu_op_t          dec_alu_op_o;
  logic [4:0]       dec_rs1_o;
  logic [4:0]       dec_rs2_o;
  logic [4:0]       dec_rd_o;
  logic [ARCH-1:0]  dec_imm_o;
  logic             dec_op_a_sel_o;
  logic             dec_op_b_sel_o;
  logic             dec_rd_we_o;
  logic             dec_mem_re_o;
  logic             dec_mem_we_o;
  logic             dec_branch_o;
  logic             dec_jump_o;
  logic [2:0]       dec_funct3_o;
  logic [ARCH-1:0]  dec_pc_o;
  logic             dec_illegal_o;

  modport slave (
    input  flush_i, instr_valid_i, instr_i, pc_i, dec_ready_i,
    output instr_ready_o, dec_valid_o, dec_alu_op_o, dec_rs1_o, dec_rs2_o,
           dec_rd_o, dec_imm_o, dec_op_a_sel_o, dec_op_b_sel_o, dec_rd_we_o,
           dec_mem_re_o, dec_mem_we_o, dec_branch_o, dec_jump_o,
           dec_funct3_o, dec_pc_o, dec_illegal_o
  );

  modport master (
    output flush_i, instr_valid_i, instr_i, pc_i, dec_ready_i,
    input  instr_ready_o, dec_valid_o, dec_alu_op_o, dec_rs1_o, dec_rs2_o,
           dec_rd_o, dec_imm_o, dec_op_a_sel_o, dec_op_b_sel_o, dec_rd_we_o,
           dec_mem_re_o, dec_mem_we_o, dec_branch_o, dec_jump_o,
           dec_funct3_o, dec_pc_o, dec_illegal_o
  );

endinterface

// File: rtl/friscv_imm_gen.sv
// friscv_imm_gen: combinational RV32I immediate extraction.
//   instr_i  in  32    instruction word
//   imm_o    out ARCH  sign-extended immediate (0 for formats without one)
// Shift-immediates return the bare shamt so the ALU sees the shift amount
// rather than the funct7 bits sitting above it.
module friscv_imm_gen
  import friscv_pkg::*;
(
  input  logic [31:0]      instr_i,
  output logic [ARCH-1:0]  imm_o
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (instr_i[6:0])
      OPC_OPIMM: begin
        if (instr_i[13:12] == 2'b01) imm32 = {27'd0, instr_i[24:20]};
        else                         imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      OPC_LOAD, OPC_JALR:
        imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      OPC_STORE:
        imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      OPC_BRANCH:
        imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                 instr_i[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm32 = {instr_i[31:12], 12'd0};
      OPC_JAL:
        imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                 instr_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm_o = ARCH'($signed(imm32));

endmodule

// File: rtl/friscv_decoder.sv
// friscv_decoder: RV32I decode stage between fetch and execute.
//   clk, rst_n   clock; synchronous active-low reset
//   bus          friscv_decoder_if.slave: flush, fetch handshake, decoded bundle
//   dbg_state_o  skid-buffer state (EMPTY / MAIN / FULL)
// A main output register plus one skid register give full throughput while
// keeping instr_ready_o a function of registered state only.
module friscv_decoder
  import friscv_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  friscv_decoder_if.slave    bus,
  output dec_state_e         dbg_state_o
);

  dec_state_e   state_q;
  dec_bundle_t  out_q;
  dec_bundle_t  skid_q;
  dec_bundle_t  dec_d;
  logic [ARCH-1:0] imm;
  logic         accept;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = bus.instr_i[6:0];
  assign funct3 = bus.instr_i[14:12];
  assign funct7 = bus.instr_i[31:25];

  friscv_imm_gen u_imm_gen (
    .instr_i (bus.instr_i),
    .imm_o   (imm)
  );

  always_comb begin
    dec_d          = '0;
    dec_d.alu_op   = ALU_ADD;
    dec_d.rs1      = bus.instr_i[19:15];
    dec_d.rs2      = bus.instr_i[24:20];
    dec_d.rd       = bus.instr_i[11:7];
    dec_d.imm      = imm;
    dec_d.funct3   = funct3;
    dec_d.pc       = bus.pc_i;

    case (opcode)
      OPC_OP: begin
        dec_d.rd_we = 1'b1;
        case (funct3)
          3'b000: begin
            if (funct7 == F7_BASE)     dec_d.alu_op = ALU_ADD;
            else if (funct7 == F7_ALT) dec_d.alu_op = ALU_SUB;
            else                       dec_d.illegal = 1'b1;
          end
          3'b001: begin dec_d.alu_op = ALU_SLL; dec_d.illegal = (funct7 != F7_BASE); end
          3'b010: begin dec_d.alu_op = ALU_SLT; dec_d.illegal = (funct7 != F7_BASE); end
          3'b100: begin dec_d.alu_op = ALU_XOR; dec_d.illegal = (funct7 != F7_BASE); end
          3'b101: begin
            if (funct7 == F7_BASE)     dec_d.alu_op = ALU_SLR;
            else if (funct7 == F7_ALT) dec_d.alu_op = ALU_SAR;
            else                       dec_d.illegal = 1'b1;
          end
          3'b110: begin dec_d.alu_op = ALU_OR;  dec_d.illegal = (funct7 != F7_BASE); end
          3'b111: begin dec_d.alu_op = ALU_AND; dec_d.illegal = (funct7 != F7_BASE); end
          default: dec_d.illegal = 1'b1;  // SLTU has no ALU op
        endcase
      end
      OPC_OPIMM: begin
        dec_d.op_b_sel = 1'b1;
        dec_d.rd_we    = 1'b1;
        case (funct3)
          3'b000: dec_d.alu_op = ALU_ADD;
          3'b001: begin dec_d.alu_op = ALU_SLL; dec_d.illegal = (funct7 != F7_BASE); end
          3'b010: dec_d.alu_op = ALU_SLT;
          3'b100: dec_d.alu_op = ALU_XOR;
          3'b101: begin
            if (funct7 == F7_BASE)     dec_d.alu_op = ALU_SLR;
            else if (funct7 == F7_ALT) dec_d.alu_op = ALU_SAR;
            else                       dec_d.illegal = 1'b1;
          end
          3'b110: dec_d.alu_op = ALU_OR;
          3'b111: dec_d.alu_op = ALU_AND;
          default: dec_d.illegal = 1'b1;  // SLTIU has no ALU op
        endcase
      end
      OPC_LUI: begin
        dec_d.rs1      = 5'd0;  // x0 + imm through the adder
        dec_d.op_b_sel = 1'b1;
        dec_d.rd_we    = 1'b1;
      end
      OPC_AUIPC: begin
        dec_d.op_a_sel = 1'b1;
        dec_d.op_b_sel = 1'b1;
        dec_d.rd_we    = 1'b1;
      end
      OPC_LOAD: begin
        dec_d.op_b_sel = 1'b1;
        dec_d.mem_re   = 1'b1;
        dec_d.rd_we    = 1'b1;
      end
      OPC_STORE: begin
        dec_d.op_b_sel = 1'b1;
        dec_d.mem_we   = 1'b1;
      end
      OPC_BRANCH: begin
        dec_d.alu_op = ALU_SUB;
        dec_d.branch = 1'b1;
      end
      OPC_JAL: begin
        dec_d.op_a_sel = 1'b1;
        dec_d.op_b_sel = 1'b1;
        dec_d.jump     = 1'b1;
        dec_d.rd_we    = 1'b1;
      end
      OPC_JALR: begin
        dec_d.op_b_sel = 1'b1;
        dec_d.jump     = 1'b1;
        dec_d.rd_we    = 1'b1;
      end
      default: dec_d.illegal = 1'b1;
    endcase

    if (bus.instr_i[1:0] != 2'b11) dec_d.illegal = 1'b1;

    // Illegal bundles still flow so execute can trap, but with no side effects.
    if (dec_d.illegal) begin
      dec_d.alu_op = ALU_ADD;
      dec_d.rd_we  = 1'b0;
      dec_d.mem_re = 1'b0;
      dec_d.mem_we = 1'b0;
      dec_d.branch = 1'b0;
      dec_d.jump   = 1'b0;
    end

    if (dec_d.rd == 5'd0) dec_d.rd_we = 1'b0;
  end

  // Ready only reflects whether the skid slot is free.
  assign bus.instr_ready_o = rst_n && (state_q != ST_FULL);
  assign accept            = bus.instr_valid_i && bus.instr_ready_o;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else if (bus.flush_i) begin
      state_q <= ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            out_q   <= dec_d;
            state_q <= ST_MAIN;
          end
        end
        ST_MAIN: begin
          if (accept && bus.dec_ready_i) begin
            out_q <= dec_d;
          end else if (accept) begin
            skid_q  <= dec_d;
            state_q <= ST_FULL;
          end else if (bus.dec_ready_i) begin
            state_q <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (bus.dec_ready_i) begin
            out_q   <= skid_q;
            state_q <= ST_MAIN;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  assign dbg_state_o        = state_q;
  assign bus.dec_valid_o    = (state_q != ST_EMPTY);
  assign bus.dec_alu_op_o   = out_q.alu_op;
  assign bus.dec_rs1_o      = out_q.rs1;
  assign bus.dec_rs2_o      = out_q.rs2;
  assign bus.dec_rd_o       = out_q.rd;
  assign bus.dec_imm_o      = out_q.imm;
  assign bus.dec_op_a_sel_o = out_q.op_a_sel;
  assign bus.dec_op_b_sel_o = out_q.op_b_sel;
  assign bus.dec_rd_we_o    = out_q.rd_we;
  assign bus.dec_mem_re_o   = out_q.mem_re;
  assign bus.dec_mem_we_o   = out_q.mem_we;
  assign bus.dec_branch_o   = out_q.branch;
  assign bus.dec_jump_o     = out_q.jump;
  assign bus.dec_funct3_o   = out_q.funct3;
  assign bus.dec_pc_o       = out_q.pc;
  assign bus.dec_illegal_o  = out_q.illegal;

endmodule

// File: tb/tb_friscv_decoder.sv
// tb_friscv_decoder: directed checks of decode mapping, skid buffering,
// flush and reset for friscv_decoder.
module tb_friscv_decoder;
  import friscv_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  friscv_decoder_if bus();
  dec_state_e dbg_state;

  friscv_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int total = 0;
  int bad = 0;
  logic [ARCH-1:0] exp_q[$];
  logic [ARCH-1:0] sb_e;

  // ---------------- driver / check tasks ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [ARCH-1:0] pc);
    bus.instr_valid_i = v;
    bus.instr_i       = ins;
    bus.pc_i          = pc;
  endtask

  task automatic chk_dec(input string tag, input logic [3:0] alu,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic a_sel, input logic b_sel, input logic we,
                         input logic re, input logic mwe, input logic br, input logic jmp,
                         input logic ill, input logic [ARCH-1:0] pc);
    chk({tag, ".valid"},   bus.dec_valid_o, 1'b1);
    chk({tag, ".alu"},     bus.dec_alu_op_o, alu);
    chk({tag, ".rs1"},     bus.dec_rs1_o, rs1);
    chk({tag, ".rs2"},     bus.dec_rs2_o, rs2);
    chk({tag, ".rd"},      bus.dec_rd_o, rd);
    chk({tag, ".a_sel"},   bus.dec_op_a_sel_o, a_sel);
    chk({tag, ".b_sel"},   bus.dec_op_b_sel_o, b_sel);
    chk({tag, ".rd_we"},   bus.dec_rd_we_o, we);
    chk({tag, ".mem_re"},  bus.dec_mem_re_o, re);
    chk({tag, ".mem_we"},  bus.dec_mem_we_o, mwe);
    chk({tag, ".branch"},  bus.dec_branch_o, br);
    chk({tag, ".jump"},    bus.dec_jump_o, jmp);
    chk({tag, ".illegal"}, bus.dec_illegal_o, ill);
    chk({tag, ".pc"},      bus.dec_pc_o, pc);
  endtask

  // ---------------- scoreboard: order / loss / duplication ----------------
  always @(negedge clk) begin
    if (!rst_n || bus.flush_i) begin
      exp_q.delete();
    end else begin
      if (bus.dec_valid_o && bus.dec_ready_i) begin
        chk("sb.nonempty", (exp_q.size() > 0), 1'b1);
        if (exp_q.size() > 0) begin
          sb_e = exp_q.pop_front();
          chk("sb.pc", bus.dec_pc_o, sb_e);
        end
      end
      if (bus.instr_valid_i && bus.instr_ready_o) exp_q.push_back(bus.pc_i);
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    bus.flush_i     = 1'b0;
    bus.dec_ready_i = 1'b0;
    drive(1'b0, 32'h0, '0);

    // reset state
    step(); step();
    chk("rst.valid", bus.dec_valid_o, 1'b0);
    chk("rst.ready", bus.instr_ready_o, 1'b0);
    chk("rst.alu",   bus.dec_alu_op_o, ALU_ADD);
    chk("rst.imm",   bus.dec_imm_o, '0);
    chk("rst.pc",    bus.dec_pc_o, '0);
    chk("rst.state", dbg_state, ST_EMPTY);
    rst_n = 1'b1;
    #1;
    chk("rel.ready", bus.instr_ready_o, 1'b1);

    // decode mapping, streamed back-to-back with execute always ready
    bus.dec_ready_i = 1'b1;
    drive(1'b1, 32'hFFB10093, 32'h100);  // ADDI x1,x2,-5
    step();
    chk_dec("addi", ALU_ADD, 5'd2, 5'd27, 5'd1, 0, 1, 1, 0, 0, 0, 0, 0, 32'h100);
    chk("addi.imm", bus.dec_imm_o, 32'hFFFFFFFB);
    chk("addi.f3", bus.dec_funct3_o, 3'b000);

    drive(1'b1, 32'h402081B3, 32'h104);  // SUB x3,x1,x2
    step();
    chk_dec("sub", ALU_SUB, 5'd1, 5'd2, 5'd3, 0, 0, 1, 0, 0, 0, 0, 0, 32'h104);

    drive(1'b1, 32'h003130B3, 32'h108);  // SLTU x1,x2,x3
    step();
    chk_dec("sltu", ALU_ADD, 5'd2, 5'd3, 5'd1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h108);

    drive(1'b1, 32'h4032D293, 32'h10C);  // SRAI x5,x5,3
    step();
    chk_dec("srai", ALU_SAR, 5'd5, 5'd3, 5'd5, 0, 1, 1, 0, 0, 0, 0, 0, 32'h10C);
    chk("srai.imm", bus.dec_imm_o, 32'd3);

    drive(1'b1, 32'h0032D293, 32'h110);  // SRLI x5,x5,3
    step();
    chk_dec("srli", ALU_SLR, 5'd5, 5'd3, 5'd5, 0, 1, 1, 0, 0, 0, 0, 0, 32'h110);
    chk("srli.imm", bus.dec_imm_o, 32'd3);

    drive(1'b1, 32'h00000000, 32'h114);  // all-zero word
    step();
    chk_dec("zero", ALU_ADD, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h114);

    drive(1'b1, 32'h123450B7, 32'h118);  // LUI x1,0x12345
    step();
    chk_dec("lui", ALU_ADD, 5'd0, 5'd3, 5'd1, 0, 1, 1, 0, 0, 0, 0, 0, 32'h118);
    chk("lui.imm", bus.dec_imm_o, 32'h12345000);

    drive(1'b1, 32'h0020A423, 32'h11C);  // SW x2,8(x1)
    step();
    chk_dec("sw", ALU_ADD, 5'd1, 5'd2, 5'd8, 0, 1, 0, 0, 1, 0, 0, 0, 32'h11C);
    chk("sw.imm", bus.dec_imm_o, 32'd8);
    chk("sw.f3", bus.dec_funct3_o, 3'b010);

    drive(1'b1, 32'hFE208EE3, 32'h120);  // BEQ x1,x2,-4
    step();
    chk_dec("beq", ALU_SUB, 5'd1, 5'd2, 5'd29, 0, 0, 0, 0, 0, 1, 0, 0, 32'h120);
    chk("beq.imm", bus.dec_imm_o, 32'hFFFFFFFC);

    drive(1'b1, 32'h008000EF, 32'h124);  // JAL x1,8
    step();
    chk_dec("jal", ALU_ADD, 5'd0, 5'd8, 5'd1, 1, 1, 1, 0, 0, 0, 1, 0, 32'h124);
    chk("jal.imm", bus.dec_imm_o, 32'd8);

    drive(1'b0, 32'h0, '0);
    step();
    chk("drain.valid", bus.dec_valid_o, 1'b0);

    // backpressure: three instructions against a stalled execute stage
    bus.dec_ready_i = 1'b0;
    drive(1'b1, 32'hFFB10093, 32'h200);
    step();
    chk("bp1.valid", bus.dec_valid_o, 1'b1);
    chk("bp1.ready", bus.instr_ready_o, 1'b1);
    chk("bp1.pc",    bus.dec_pc_o, 32'h200);
    drive(1'b1, 32'h402081B3, 32'h204);
    step();
    chk("bp2.ready", bus.instr_ready_o, 1'b0);
    chk("bp2.state", dbg_state, ST_FULL);
    chk("bp2.pc",    bus.dec_pc_o, 32'h200);
    drive(1'b1, 32'h4032D293, 32'h208);
    step();
    chk("bp3.ready", bus.instr_ready_o, 1'b0);
    chk("bp3.pc",    bus.dec_pc_o, 32'h200);
    chk("bp3.alu",   bus.dec_alu_op_o, ALU_ADD);
    bus.dec_ready_i = 1'b1;
    step();
    chk("rel1.pc",    bus.dec_pc_o, 32'h204);
    chk("rel1.alu",   bus.dec_alu_op_o, ALU_SUB);
    chk("rel1.ready", bus.instr_ready_o, 1'b1);
    step();
    chk("rel2.pc",  bus.dec_pc_o, 32'h208);
    chk("rel2.alu", bus.dec_alu_op_o, ALU_SAR);
    drive(1'b0, 32'h0, '0);
    step();
    chk("rel3.valid", bus.dec_valid_o, 1'b0);

    // flush while FULL, with an instruction offered at the same time
    bus.dec_ready_i = 1'b0;
    drive(1'b1, 32'hFFB10093, 32'h300);
    step();
    drive(1'b1, 32'h402081B3, 32'h304);
    step();
    chk("fl.full", dbg_state, ST_FULL);
    bus.flush_i = 1'b1;
    drive(1'b1, 32'h0032D293, 32'h308);
    step();
    bus.flush_i = 1'b0;
    drive(1'b0, 32'h0, '0);
    chk("fl.valid", bus.dec_valid_o, 1'b0);
    chk("fl.ready", bus.instr_ready_o, 1'b1);
    bus.dec_ready_i = 1'b1;
    step();
    chk("fl.none", bus.dec_valid_o, 1'b0);

    // flush while MAIN beats a real accept
    bus.dec_ready_i = 1'b0;
    drive(1'b1, 32'hFFB10093, 32'h310);
    step();
    bus.flush_i = 1'b1;
    drive(1'b1, 32'h402081B3, 32'h314);
    chk("flm.ready", bus.instr_ready_o, 1'b1);
    step();
    bus.flush_i = 1'b0;
    drive(1'b0, 32'h0, '0);
    chk("flm.valid", bus.dec_valid_o, 1'b0);
    bus.dec_ready_i = 1'b1;
    step();
    chk("flm.none", bus.dec_valid_o, 1'b0);

    // reset mid-stream
    bus.dec_ready_i = 1'b0;
    drive(1'b1, 32'hFFB10093, 32'h400);
    step();
    drive(1'b1, 32'h402081B3, 32'h404);
    rst_n = 1'b0;
    #1;
    chk("mrst.ready_now", bus.instr_ready_o, 1'b0);
    step();
    chk("mrst.valid", bus.dec_valid_o, 1'b0);
    chk("mrst.ready", bus.instr_ready_o, 1'b0);
    chk("mrst.pc",    bus.dec_pc_o, '0);
    chk("mrst.imm",   bus.dec_imm_o, '0);
    chk("mrst.rd",    bus.dec_rd_o, 5'd0);
    chk("mrst.rd_we", bus.dec_rd_we_o, 1'b0);
    step();
    chk("mrst.ready2", bus.instr_ready_o, 1'b0);
    rst_n = 1'b1;
    bus.dec_ready_i = 1'b1;
    drive(1'b1, 32'h123450B7, 32'h500);
    step();
    chk_dec("post_rst", ALU_ADD, 5'd0, 5'd3, 5'd1, 0, 1, 1, 0, 0, 0, 0, 0, 32'h500);
    chk("post_rst.imm", bus.dec_imm_o, 32'h12345000);
    drive(1'b0, 32'h0, '0);
    step();
    chk("post_rst.drain", bus.dec_valid_o, 1'b0);
    step();

    chk("sb.drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
